gpio_in_cond: RTL

Input-side conditioner for the 6502 test SoC: takes WIDTH asynchronous board pins (buttons, switches, header inputs), synchronizes and debounces them, and presents clean levels for the CPU GPIO input port. It also emits per-bit rise/fall strobes, keeps sticky write-1-to-clear edge-pending flags and drives a maskable interrupt request. It sits between the pad ring and the gpio_i input of tst_6502, complementing the existing LED drive on gpio_o.

---
 rtl/gpio_in_cond_pkg.sv | 17 +
 rtl/gpio_in_cond_debounce_bit.sv | 68 ++++++
 rtl/gpio_in_cond.sv | 68 ++++++
 3 files changed

// File: rtl/gpio_in_cond_pkg.sv
// Shared constants for the GPIO input conditioner: default sizing and the
// helper that turns a clock frequency into a debounce tick divider.
package gpio_in_cond_pkg;

    localparam int unsigned ClkHz  = 12_000_000;
    localparam int unsigned TickHz = 1_000;

    function automatic int unsigned ticks_for(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefTickDiv = ticks_for(ClkHz, TickHz);
    localparam int unsigned DefStable  = 4;

endpackage

// File: rtl/gpio_in_cond_debounce_bit.sv
// One conditioned input: 2-FF synchronizer, tick-sampled stability counter,
// and the debounced level with its registered rise/fall strobes.
module gpio_in_cond_debounce_bit
    import gpio_in_cond_pkg::*;
#(
    parameter int unsigned STABLE = DefStable
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic tick_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(STABLE);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            db_q, db_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (tick_i) begin
            if (sync2_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                // STABLE-th consecutive differing sample: accept the new level
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: shared debounce prescaler, per-bit debouncers,
// sticky write-1-to-clear edge-pending flags and a maskable interrupt.
module gpio_in_cond
    import gpio_in_cond_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned TICK_DIV = DefTickDiv,
    parameter int unsigned STABLE   = DefStable
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] clr_i,
    input  logic [WIDTH-1:0] irq_en_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] pend_o,
    output logic             irq_o
);

    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    logic [PreW-1:0]  pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             irq_q, irq_d;

    assign tick = (pre_q == PreLast);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
        // A new edge outranks a clear arriving in the same cycle
        pend_d = (pend_q & ~clr_i) | rise_o | fall_o;
        irq_d  = |(pend_q & irq_en_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_in_cond_debounce_bit #(
            .STABLE(STABLE)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .pin_i  (pin_i[i]),
            .tick_i (tick),
            .db_o   (db_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

    assign pend_o = pend_q;
    assign irq_o  = irq_q;

endmodule
